// File: rtl/even_parity_pkg.sv
// Definitions shared by the even-parity generator and checker paths.
package even_parity_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Widest word the parity helper accepts; narrower words are zero-extended,
    // which leaves the XOR reduction unchanged.
    localparam int MAX_DATA_W = 64;

    function automatic logic even_parity(input logic [MAX_DATA_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/even_parity_checker_shifter.sv
// LSB-first deserializer for the data field of a parity frame.
module parity_rx_shifter #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift_en,
    input  logic              bit_in,
    output logic [DATA_W-1:0] data,
    output logic              last
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [IDX_W-1:0] idx;

    // Each accepted bit lands at the current index, so the word fills LSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            idx  <= '0;
        end else if (clear) begin
            data <= '0;
            idx  <= '0;
        end else if (shift_en) begin
            data[idx] <= bit_in;
            idx       <= idx + 1'b1;
        end
    end

    assign last = (idx == IDX_W'(DATA_W - 1));

endmodule

// File: rtl/even_parity_checker.sv
// Serial even-parity frame receiver with a single-entry valid/ready output
// and a saturating error counter.
module even_parity_checker
    import even_parity_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_valid,
    input  logic              serial_in,
    output logic [DATA_W-1:0] data_out,
    output logic              parity_err,
    output logic              frame_err,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              overrun,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  err_count
);

    state_t            state;
    state_t            state_next;
    logic              start;
    logic              shift;
    logic              frame_done;
    logic              last_bit;
    logic              rx_parity;
    logic [DATA_W-1:0] rx_data;
    logic              new_parity_err;
    logic              new_frame_err;
    logic              load;
    logic              drop;

    parity_rx_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .clear    (start),
        .shift_en (shift),
        .bit_in   (serial_in),
        .data     (rx_data),
        .last     (last_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        shift      = 1'b0;
        frame_done = 1'b0;
        if (bit_valid) begin
            case (state)
                IDLE: begin
                    if (serial_in == START_BIT) begin
                        state_next = DATA;
                        start      = 1'b1;
                    end
                end
                DATA: begin
                    shift = 1'b1;
                    if (last_bit) begin
                        state_next = PARITY;
                    end
                end
                PARITY: state_next = STOP;
                STOP: begin
                    state_next = IDLE;
                    frame_done = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_parity <= 1'b0;
        end else if (bit_valid && state == PARITY) begin
            rx_parity <= serial_in;
        end
    end

    assign new_parity_err = even_parity(MAX_DATA_W'(rx_data)) ^ rx_parity;
    assign new_frame_err  = (serial_in != STOP_BIT);

    // A finished frame is only accepted when the output slot is free or being
    // emptied this very cycle; otherwise it is discarded and flagged.
    assign load = frame_done && (!data_valid || data_ready);
    assign drop = frame_done && data_valid && !data_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= drop;
            if (load) begin
                data_out   <= rx_data;
                parity_err <= new_parity_err;
                frame_err  <= new_frame_err;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

    // Clearing wins over counting an errored frame on the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (load && (new_parity_err || new_frame_err) &&
                     err_count != {CNT_W{1'b1}}) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule
